// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - CPU 32-bit bus to byte-wide async SRAM bridge, 1/2/4 little-endian beats
// Optional alignment trap enabled by defining MEM_BRIDGE_ALIGN_CHECK_EN.
module mem_bridge #(
  parameter int ADDR_W      = 19,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [31:0]       bus,
  input  logic [31:0]       addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_size,
  output logic              mem_wait,
  output logic              misaligned,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata,
  output logic              sram_oe,
  output logic              sram_we
);
  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [1:0]        beat;
  logic [1:0]        last_beat;
  logic [2:0]        cyc;
  logic              is_write;
  logic              is_signed;
  logic              fault;
  logic [31:0]       wdata;
  logic [31:0]       rdata;

  logic              req;
  logic              req_byte;
  logic              req_half;
  logic [1:0]        req_last;
  logic              align_fault;
  logic              beat_end;
  logic [1:0]        nxt_beat;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       load_data;
  logic              drive_bus;
  wire               unused_addr = ^addr[31:ADDR_W];

  assign req       = mem_read | mem_write;
  assign req_byte  = mem_size[3] | mem_size[2];
  assign req_half  = ~req_byte & (mem_size[1] | mem_size[0]);
  assign req_last  = req_byte ? 2'd0 : (req_half ? 2'd1 : 2'd3);
  assign beat_end  = (cyc == 3'(WAIT_STATES));
  assign nxt_beat  = beat + 2'd1;
  assign next_addr = base + ADDR_W'(nxt_beat);

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
  assign align_fault = (req_half & addr[0]) | (~req_byte & ~req_half & (addr[1:0] != 2'b00));
`else
  assign align_fault = 1'b0;
`endif

  always_comb begin
    load_data = rdata;
    case (last_beat)
      2'd0:    load_data = {{24{is_signed & rdata[7]}}, rdata[7:0]};
      2'd1:    load_data = {{16{is_signed & rdata[15]}}, rdata[15:0]};
      default: load_data = rdata;
    endcase
    if (fault) load_data = 32'd0;
  end

  // The bus is shared with the CPU, so only drive it while a load is actually being consumed.
  assign drive_bus  = (state == DONE) & ~is_write & mem_read;
  assign bus        = drive_bus ? load_data : 32'bz;
  assign mem_wait   = req & (state != DONE);
  assign misaligned = fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      base       <= '0;
      beat       <= '0;
      last_beat  <= '0;
      cyc        <= '0;
      is_write   <= 1'b0;
      is_signed  <= 1'b0;
      fault      <= 1'b0;
      wdata      <= '0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_oe    <= 1'b0;
      sram_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            base      <= addr[ADDR_W-1:0];
            last_beat <= req_last;
            is_write  <= mem_write;
            is_signed <= mem_size[3] | mem_size[1];
            wdata     <= bus;
            beat      <= '0;
            cyc       <= '0;
            if (align_fault) begin
              fault <= 1'b1;
              state <= DONE;
            end else begin
              state      <= BEAT;
              sram_addr  <= addr[ADDR_W-1:0];
              sram_wdata <= bus[7:0];
              sram_we    <= mem_write;
              sram_oe    <= ~mem_write;
            end
          end
        end
        BEAT: begin
          // A dropped request means the instruction was trapped; a partial store is tolerated.
          if (!req) begin
            state   <= IDLE;
            sram_oe <= 1'b0;
            sram_we <= 1'b0;
          end else if (beat_end) begin
            if (!is_write) rdata[{beat, 3'b000} +: 8] <= sram_rdata;
            cyc <= '0;
            if (beat == last_beat) begin
              state   <= DONE;
              sram_oe <= 1'b0;
              sram_we <= 1'b0;
            end else begin
              beat       <= nxt_beat;
              sram_addr  <= next_addr;
              sram_wdata <= wdata[{nxt_beat, 3'b000} +: 8];
            end
          end else begin
            cyc <= cyc + 3'd1;
          end
        end
        DONE: begin
          if (!req) begin
            state <= IDLE;
            fault <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - directed vector bench for mem_bridge (WAIT_STATES 0 and 2 instances)
module tb_mem_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_size = '0;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_val = '0;
  wire  [31:0] bus0, bus2;
  logic        wait0, mis0, oe0, we0, wait2, mis2, oe2, we2;
  logic [18:0] a0, a2;
  logic [7:0]  wd0, wd2, rd0, rd2;

  always #5 clk = ~clk;

  assign bus0 = tb_drv ? tb_val : 32'bz;
  assign bus2 = tb_drv ? tb_val : 32'bz;

  mem_bridge #(.ADDR_W(19), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .addr(addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_wait(wait0), .misaligned(mis0),
    .sram_addr(a0), .sram_wdata(wd0), .sram_rdata(rd0), .sram_oe(oe0), .sram_we(we0));

  mem_bridge #(.ADDR_W(19), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .addr(addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_wait(wait2), .misaligned(mis2),
    .sram_addr(a2), .sram_wdata(wd2), .sram_rdata(rd2), .sram_oe(oe2), .sram_we(we2));

  logic [7:0] mem0 [0:524287];
  logic [7:0] mem2 [0:524287];
  localparam logic [18:0] PA [9] = '{19'h00100, 19'h00101, 19'h00102, 19'h00103, 19'h00104,
                                     19'h00105, 19'h00200, 19'h7FFFF, 19'h00000};
  localparam logic [7:0]  PD [9] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hCD, 8'h9A, 8'h80, 8'h34, 8'h92};

  assign rd0 = oe0 ? mem0[a0] : 8'h00;
  assign rd2 = oe2 ? mem2[a2] : 8'h00;

  int   oe_cnt0 = 0, we_cnt0 = 0, oe_cnt2 = 0, we_cnt2 = 0;
  logic both_seen = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        mem0[PA[i]] <= PD[i];
        mem2[PA[i]] <= PD[i];
      end
    end else begin
      if (we0) mem0[a0] <= wd0;
      if (we2) mem2[a2] <= wd2;
    end
    if (oe0) oe_cnt0 <= oe_cnt0 + 1;
    if (we0) we_cnt0 <= we_cnt0 + 1;
    if (oe2) oe_cnt2 <= oe_cnt2 + 1;
    if (we2) we_cnt2 <= we_cnt2 + 1;
    if ((oe0 && we0) || (oe2 && we2)) both_seen <= 1'b1;
  end

  int nvec = 0, nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          sel;
    bit          wr;
    bit          rdx;
    logic [3:0]  size;
    logic [31:0] a;
    logic [31:0] wd;
    bit          chk;
    logic [31:0] exp_rd;
    int          lat;
    int          oes;
    int          wes;
    bit          mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input bit sel, input bit wr, input bit rdx,
                     input logic [3:0] size, input logic [31:0] a, input logic [31:0] wd,
                     input bit chk, input logic [31:0] exp_rd, input int lat,
                     input int oes, input int wes, input bit mis);
    vec_t v;
    v.name = n; v.sel = sel; v.wr = wr; v.rdx = rdx; v.size = size; v.a = a; v.wd = wd;
    v.chk = chk; v.exp_rd = exp_rd; v.lat = lat; v.oes = oes; v.wes = wes; v.mis = mis;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int lat, oe_s, we_s;
    logic [31:0] rd;
    logic mis;
    oe_s = v.sel ? oe_cnt2 : oe_cnt0;
    we_s = v.sel ? we_cnt2 : we_cnt0;
    addr = v.a; mem_size = v.size; mem_write = v.wr; mem_read = !v.wr || v.rdx;
    tb_drv = v.wr; tb_val = v.wd;
    for (lat = 1; lat <= 200; lat++) begin
      @(posedge clk); #1;
      if (!(v.sel ? wait2 : wait0)) break;
    end
    rd  = v.sel ? bus2 : bus0;
    mis = v.sel ? mis2 : mis0;
    mem_read = 1'b0; mem_write = 1'b0; tb_drv = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s latency", v.name), lat, v.lat);
    if (v.chk) check($sformatf("%s data", v.name), rd, v.exp_rd);
    check($sformatf("%s oe cycles", v.name), (v.sel ? oe_cnt2 : oe_cnt0) - oe_s, v.oes);
    check($sformatf("%s we cycles", v.name), (v.sel ? we_cnt2 : we_cnt0) - we_s, v.wes);
    check($sformatf("%s misaligned", v.name), {31'd0, mis}, {31'd0, v.mis});
    check($sformatf("%s misaligned idle", v.name), {31'd0, v.sel ? mis2 : mis0}, 32'd0);
  endtask

  initial begin
    //   name          sel wr rdx size   addr          wdata         chk exp            lat oe we mis
    add("lw_100",      0, 0, 0, 4'h0, 32'h100,     32'h0,        1, 32'h12345678, 5,  4, 0, 0);
    add("lb_200",      0, 0, 0, 4'h8, 32'h200,     32'h0,        1, 32'hFFFFFF80, 2,  1, 0, 0);
    add("lbu_200",     0, 0, 0, 4'h4, 32'h200,     32'h0,        1, 32'h00000080, 2,  1, 0, 0);
    add("sw_300",      0, 1, 0, 4'h0, 32'h300,     32'hAABBCCDD, 0, 32'h0,        5,  0, 4, 0);
    add("lw_300",      0, 0, 0, 4'h0, 32'h300,     32'h0,        1, 32'hAABBCCDD, 5,  4, 0, 0);
    add("sh_302",      0, 1, 0, 4'h1, 32'h302,     32'h00001234, 0, 32'h0,        3,  0, 2, 0);
    add("lw_300_sh",   0, 0, 0, 4'h0, 32'h300,     32'h0,        1, 32'h1234CCDD, 5,  4, 0, 0);
    add("lh_104",      0, 0, 0, 4'h2, 32'h104,     32'h0,        1, 32'hFFFF9ACD, 3,  2, 0, 0);
    add("lhu_104",     0, 0, 0, 4'h1, 32'h104,     32'h0,        1, 32'h00009ACD, 3,  2, 0, 0);
    add("sb_305",      0, 1, 0, 4'h4, 32'h305,     32'h000000EE, 0, 32'h0,        2,  0, 1, 0);
    add("lb_305",      0, 0, 0, 4'h8, 32'h305,     32'h0,        1, 32'hFFFFFFEE, 2,  1, 0, 0);
    add("rw_306",      0, 1, 1, 4'h4, 32'h306,     32'h00000011, 1, 32'h00000011, 2,  0, 1, 0);
    add("lbu_306",     0, 0, 0, 4'h4, 32'h306,     32'h0,        1, 32'h00000011, 2,  1, 0, 0);
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    add("lw_101",      0, 0, 0, 4'h0, 32'h101,     32'h0,        1, 32'h00000000, 1,  0, 0, 1);
    add("lh_7ffff_ws2",1, 0, 0, 4'h2, 32'h7FFFF,   32'h0,        1, 32'h00000000, 1,  0, 0, 1);
`else
    add("lw_101",      0, 0, 0, 4'h0, 32'h101,     32'h0,        1, 32'hCD123456, 5,  4, 0, 0);
    add("lh_7ffff_ws2",1, 0, 0, 4'h2, 32'h7FFFF,   32'h0,        1, 32'hFFFF9234, 7,  6, 0, 0);
`endif
    add("lw_100_ws2",  1, 0, 0, 4'h0, 32'hFFF80100, 32'h0,       1, 32'h12345678, 13, 12, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset mem_wait", {31'd0, wait0}, 32'd0);
    check("reset sram_oe", {31'd0, oe0}, 32'd0);
    check("reset sram_we", {31'd0, we0}, 32'd0);
    check("reset sram_addr", {13'd0, a0}, 32'd0);
    check("reset sram_wdata", {24'd0, wd0}, 32'd0);
    check("reset misaligned", {31'd0, mis0}, 32'd0);
    tb_drv = 1'b1; tb_val = 32'hA5A5A5A5;
    #1;
    check("reset bus released", bus0, 32'hA5A5A5A5);
    tb_drv = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // mem_wait must rise combinationally, before the bridge has seen any edge
    addr = 32'h100; mem_size = 4'h0; mem_read = 1'b1;
    #1;
    check("mem_wait same cycle", {31'd0, wait0}, 32'd1);
    mem_read = 1'b0;
    @(posedge clk); #1;
    check("no access when req dropped", {31'd0, oe0}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // DONE with mem_read already dropped: the bridge must let go of the bus
    addr = 32'h100; mem_size = 4'h0; mem_read = 1'b1;
    for (int i = 0; i < 50 && wait0; i++) begin
      @(posedge clk); #1;
    end
    check("done reached", {31'd0, wait0}, 32'd0);
    mem_read = 1'b0; tb_drv = 1'b1; tb_val = 32'hA5A5A5A5;
    #1;
    check("bus released in done", bus0, 32'hA5A5A5A5);
    tb_drv = 1'b0;
    @(posedge clk); #1;

    // reset during the second beat of a word store
    addr = 32'h300; mem_size = 4'h0; mem_write = 1'b1; tb_drv = 1'b1; tb_val = 32'h01020304;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("store in progress", {31'd0, we0}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset mid-write sram_we", {31'd0, we0}, 32'd0);
    check("reset mid-write sram_oe", {31'd0, oe0}, 32'd0);
    check("reset mid-write mem_wait", {31'd0, wait0}, 32'd1);
    check("reset mid-write misaligned", {31'd0, mis0}, 32'd0);
    check("reset mid-write sram_addr", {13'd0, a0}, 32'd0);
    reset = 1'b0; mem_write = 1'b0; tb_drv = 1'b0;
    @(posedge clk); #1;
    check("idle after reset mem_wait", {31'd0, wait0}, 32'd0);

    // request dropped mid-beat on the slow instance, then a clean access afterwards
    addr = 32'h100; mem_size = 4'h0; mem_read = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("abort oe active", {31'd0, oe2}, 32'd1);
    mem_read = 1'b0;
    @(posedge clk); #1;
    check("abort oe released", {31'd0, oe2}, 32'd0);
    run_vec(vecs[vecs.size() - 1]);

    check("oe and we never both high", {31'd0, both_seen}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
